// File: rtl/fetch_insn_pkg.sv
// Shared definitions for the instruction fetch slice: default widths,
// reset PC and the fetch FSM state encoding.
package fetch_insn_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int INSN_W_DEF = 32;
  localparam int DEPTH_DEF  = 2;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 10'h000;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  // Width needed to hold an occupancy count of 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {instruction, pc} pairs.
// Flush empties the buffer and wins over a simultaneous push.
module fetch_fifo
  import fetch_insn_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 42,
  localparam int CW   = cnt_w(DEPTH),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output logic [W-1:0]  head_o,
  output logic          full_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [CW-1:0] count_q;
  logic          do_pop_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign do_pop_s = pop_i && (count_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= ptr_inc(wr_q);
      end
      if (do_pop_s) begin
        rd_q <= ptr_inc(rd_q);
      end
      count_q <= count_q + CW'(push_i) - CW'(do_pop_s);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_q];
  assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_insn_chk.sv
// Protocol checker for the fetch buffer: a push may never land on a full
// FIFO unless a pop or flush makes room in the same cycle.
module fetch_insn_chk (
  input logic clk,
  input logic rst,
  input logic push_i,
  input logic pop_i,
  input logic flush_i,
  input logic full_i
);

  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst) !(push_i && full_i && !pop_i && !flush_i)
  );

endmodule

// File: rtl/fetch_insn.sv
// Instruction fetch initiator: drives the 1-cycle-latency ROM, tracks the
// in-flight read and hands buffered words to decode over valid/ready.
module fetch_insn
  import fetch_insn_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INSN_W = INSN_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INSN_W-1:0] mem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              insn_valid,
  input  logic              insn_ready,
  output logic [INSN_W-1:0] insn_data,
  output logic [ADDR_W-1:0] insn_pc
);

  localparam int EW = INSN_W + ADDR_W;
  localparam int CW = cnt_w(DEPTH);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] inflight_pc_q;
  logic              inflight_q;

  logic [CW-1:0]     count_s;
  logic [EW-1:0]     head_s;
  logic              full_s;
  logic              pop_s;
  logic              issue_s;

  assign insn_valid = (count_s != '0);
  assign pop_s      = insn_valid && insn_ready;

  // Issue only when the returning word is guaranteed a free slot.
  always_comb begin
    issue_s = 1'b0;
    if ((state_q == ST_RUN) && !redirect_valid) begin
      issue_s = (({1'b0, count_s} + (CW+1)'(inflight_q)) <
                 ((CW+1)'(DEPTH) + (CW+1)'(pop_s)));
    end else begin
      issue_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_BOOT;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else if (redirect_valid) begin
      state_q    <= ST_RUN;
      fetch_pc_q <= redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          inflight_q <= 1'b0;
        end
        ST_RUN: begin
          inflight_q <= issue_s;
          if (issue_s) begin
            inflight_pc_q <= fetch_pc_q;
            fetch_pc_q    <= fetch_pc_q + ADDR_W'(1);
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          inflight_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i ({mem_rdata, inflight_pc_q}),
    .pop_i       (pop_s),
    .flush_i     (redirect_valid),
    .count_o     (count_s),
    .head_o      (head_s),
    .full_o      (full_s)
  );

  fetch_insn_chk u_chk (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q),
    .pop_i   (pop_s),
    .flush_i (redirect_valid),
    .full_i  (full_s)
  );

  assign mem_addr  = fetch_pc_q;
  assign insn_data = head_s[EW-1:ADDR_W];
  assign insn_pc   = head_s[ADDR_W-1:0];

endmodule
